exec_unit: RTL

- Parametrised successor to the single-cycle execute stage, sitting between decode/register-read and the memory stage.
- Adds valid/ready handshakes on both sides, configurable datapath width and I-type ALU and LUI support.
- Replaces the single "previous store" check with a DEPTH-entry outstanding-store tracker; loads that alias any in-flight store stall.
- One registered output stage, latency 1.

---
 rtl/exec_unit.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/exec_unit.sv
// Execute stage. Decodes RV32 load/store/R/I-ALU/LUI, computes the ALU result or effective address, and registers it.
// Latency: 1 cycle from accept to out_valid_o. The output register holds while out_valid_o & !out_ready_i.
// Backpressure: in_ready_o drops while the output is held, or while a load aliases an in-flight store, or while a store finds the tracker full.
//
// Optional feature: the EXEC_PERF_CNT_EN macro adds the stall_cycles_o and instr_count_o counters.
//
// Ports:
//   clk, rst_n (async, active-low)
//   in_valid_i/in_ready_o, instr_i, rs1_i, rs2_i   : upstream handshake and operands
//   out_valid_o/out_ready_i, instr_o, alu_result_o, rs2_o, sel_rd_o : registered result to the memory stage
//   st_done_i     : the memory stage retired the oldest outstanding store
//   stall_o       : a valid instruction is held back by a hazard
//   st_count_o    : number of outstanding stores
module exec_unit #(
    parameter int XLEN     = 32,
    parameter int ST_DEPTH = 4,
    parameter int ADDR_LSB = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [31:0]                   instr_i,
    input  logic [XLEN-1:0]               rs1_i,
    input  logic [XLEN-1:0]               rs2_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [31:0]                   instr_o,
    output logic [XLEN-1:0]               alu_result_o,
    output logic [XLEN-1:0]               rs2_o,
    output logic [4:0]                    sel_rd_o,
    input  logic                          st_done_i,
    output logic                          stall_o,
    output logic [$clog2(ST_DEPTH+1)-1:0] st_count_o
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0]                   stall_cycles_o,
    output logic [31:0]                   instr_count_o
`endif
);

    localparam int SH_W  = $clog2(XLEN);
    localparam int PTR_W = (ST_DEPTH > 1) ? $clog2(ST_DEPTH) : 1;
    localparam int CNT_W = $clog2(ST_DEPTH + 1);
    localparam int TAG_W = XLEN - ADDR_LSB;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ST_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Output stage
    logic              out_vld_q, out_vld_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;

    // Outstanding-store tracker: circular FIFO of word tags with a per-entry valid bit
    logic [TAG_W-1:0]  tag_q [ST_DEPTH];
    logic [TAG_W-1:0]  tag_d [ST_DEPTH];
    logic [ST_DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Decode / ALU
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_load, is_store, is_r, is_i;
    logic [XLEN-1:0]   imm_i, imm_s, imm_u, oper2, alu_res, sra_res, res;
    logic [SH_W-1:0]   shamt;
    logic [4:0]        rd_sel;
    logic              ld_hit, hazard, accept, push, pop;

    always_comb begin
        opcode   = instr_i[6:0];
        funct3   = instr_i[14:12];
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        is_r     = (opcode == OP_R);
        is_i     = (opcode == OP_I);

        imm_i = XLEN'($signed(instr_i[31:20]));
        imm_s = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
        imm_u = XLEN'($signed({instr_i[31:12], 12'b0}));

        oper2   = is_r ? rs2_i : imm_i;
        shamt   = oper2[SH_W-1:0];
        // Kept as its own statement so the arithmetic shift is not turned unsigned by a mixed-sign ternary
        sra_res = $signed(rs1_i) >>> shamt;

        alu_res = '0;
        case (funct3)
            3'b000: alu_res = (is_r && instr_i[30]) ? rs1_i - oper2 : rs1_i + oper2;
            3'b001: alu_res = rs1_i << shamt;
            3'b010: alu_res = XLEN'($signed(rs1_i) < $signed(oper2));
            3'b011: alu_res = XLEN'(rs1_i < oper2);
            3'b100: alu_res = rs1_i ^ oper2;
            3'b101: alu_res = instr_i[30] ? sra_res : rs1_i >> shamt;
            3'b110: alu_res = rs1_i | oper2;
            default: alu_res = rs1_i & oper2;
        endcase

        res    = '0;
        rd_sel = '0;
        case (opcode)
            OP_LOAD:  begin res = rs1_i + imm_i; rd_sel = instr_i[11:7]; end
            OP_STORE: res = rs1_i + imm_s;
            OP_R,
            OP_I:     begin res = alu_res;       rd_sel = instr_i[11:7]; end
            OP_LUI:   begin res = imm_u;         rd_sel = instr_i[11:7]; end
            default:  ;
        endcase

        // Compare against entries valid at the start of the cycle, so a store retiring now still blocks
        ld_hit = 1'b0;
        for (int i = 0; i < ST_DEPTH; i++) begin
            if (ent_vld_q[i] && (tag_q[i] == res[XLEN-1:ADDR_LSB])) ld_hit = 1'b1;
        end

        hazard = (is_load && ld_hit) ||
                 (is_store && (cnt_q == CNT_W'(ST_DEPTH)) && !st_done_i);

        in_ready_o = !hazard && (!out_vld_q || out_ready_i);
        stall_o    = in_valid_i && hazard;
        accept     = in_valid_i && in_ready_o;
        push       = accept && is_store;
        pop        = st_done_i && (cnt_q != '0);
    end

    always_comb begin
        out_vld_d = out_vld_q;
        instr_d   = instr_q;
        result_d  = result_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        if (accept) begin
            out_vld_d = 1'b1;
            instr_d   = instr_i;
            result_d  = res;
            rs2_d     = rs2_i;
            rd_d      = rd_sel;
        end else if (out_ready_i) begin
            out_vld_d = 1'b0;
        end

        tag_d     = tag_q;
        ent_vld_d = ent_vld_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        // Pop before push: when full, the push reuses the slot just freed
        if (pop) begin
            ent_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d            = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            tag_d[wr_ptr_q]     = res[XLEN-1:ADDR_LSB];
            ent_vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            instr_q   <= '0;
            result_q  <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            ent_vld_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < ST_DEPTH; i++) tag_q[i] <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            instr_q   <= instr_d;
            result_q  <= result_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            ent_vld_q <= ent_vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
        end
    end

    assign out_valid_o  = out_vld_q;
    assign instr_o      = instr_q;
    assign alu_result_o = result_q;
    assign rs2_o        = rs2_q;
    assign sel_rd_o     = rd_q;
    assign st_count_o   = cnt_q;

`ifdef EXEC_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'b0, stall_o};
        instr_cnt_d = instr_cnt_q + {31'b0, accept};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign instr_count_o  = instr_cnt_q;
`endif

endmodule
